// File: rtl/step_profile_gen_if.sv
// Command/status bundle between a motion controller and step_profile_gen.
// Handshake: start is a single-cycle request that is accepted only while busy=0
// (no ready); a request seen while busy=1 is dropped, and abort overrides start.
interface step_profile_gen_if #(
    parameter int POS_W = 32,
    parameter int PER_W = 24
);
    logic             start;
    logic             abort;
    logic             load_pos;
    logic [POS_W-1:0] load_val;
    logic [POS_W-1:0] target_pos;
    logic [PER_W-1:0] start_period;
    logic [PER_W-1:0] cruise_period;
    logic [PER_W-1:0] accel_dec;
    logic [POS_W-1:0] cur_step_pos;
    logic             step;
    logic             dir;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;

    modport master (
        output start, abort, load_pos, load_val, target_pos,
               start_period, cruise_period, accel_dec,
        input  cur_step_pos, step, dir, busy, done, state_dbg
    );

    modport slave (
        input  start, abort, load_pos, load_val, target_pos,
               start_period, cruise_period, accel_dec,
        output cur_step_pos, step, dir, busy, done, state_dbg
    );
endinterface

// File: rtl/step_profile_gen.sv
// Trapezoidal step-pulse generator: walks cur_step_pos toward a target with a
// linear period ramp up (ACCEL), a constant CRUISE interval and a ramp down (DECEL).
module step_profile_gen #(
    parameter int POS_W = 32,
    parameter int PER_W = 24
) (
    input logic               clk,
    input logic               rst,
    step_profile_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic             fin, fin_n;
    logic [POS_W-1:0] pos, pos_n;
    logic [POS_W-1:0] remaining, remaining_n;
    logic [POS_W-1:0] ramp_cnt, ramp_cnt_n;
    logic             dir, dir_n;
    logic             step, step_n;
    logic             done, done_n;
    logic [PER_W-1:0] period, period_n;
    logic [PER_W-1:0] ps, ps_n;
    logic [PER_W-1:0] pc, pc_n;
    logic [PER_W-1:0] acc, acc_n;
    logic [PER_W-1:0] timer, timer_n;

    logic [POS_W-1:0] base, delta, mag;
    logic [PER_W-1:0] ps_in, pc_in;
    logic [PER_W:0]   up_sum, dn_lim;
    logic [PER_W-1:0] up_per, dn_per;
    logic [POS_W-1:0] rem_dec, ramp_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fin       <= 1'b0;
            pos       <= '0;
            remaining <= '0;
            ramp_cnt  <= '0;
            dir       <= 1'b1;
            step      <= 1'b0;
            done      <= 1'b0;
            period    <= '0;
            ps        <= '0;
            pc        <= '0;
            acc       <= '0;
            timer     <= '0;
        end else begin
            state     <= state_n;
            fin       <= fin_n;
            pos       <= pos_n;
            remaining <= remaining_n;
            ramp_cnt  <= ramp_cnt_n;
            dir       <= dir_n;
            step      <= step_n;
            done      <= done_n;
            period    <= period_n;
            ps        <= ps_n;
            pc        <= pc_n;
            acc       <= acc_n;
            timer     <= timer_n;
        end
    end

    always_comb begin
        base    = bus.load_pos ? bus.load_val : pos;
        delta   = bus.target_pos - base;
        mag     = delta[POS_W-1] ? -delta : delta;
        ps_in   = (bus.start_period < PER_W'(2)) ? PER_W'(2) : bus.start_period;
        pc_in   = (bus.cruise_period < PER_W'(2)) ? PER_W'(2) : bus.cruise_period;
        // One extra bit keeps period+accel_dec exact before the clamp to Ps.
        up_sum  = {1'b0, period} + {1'b0, acc};
        up_per  = (up_sum > {1'b0, ps}) ? ps : up_sum[PER_W-1:0];
        dn_lim  = {1'b0, pc} + {1'b0, acc};
        dn_per  = ({1'b0, period} <= dn_lim) ? pc : (period - acc);
        rem_dec = remaining - POS_W'(1);
    end

    always_comb begin
        state_n     = state;
        fin_n       = 1'b0;
        pos_n       = pos;
        remaining_n = remaining;
        ramp_cnt_n  = ramp_cnt;
        dir_n       = dir;
        step_n      = 1'b0;
        done_n      = 1'b0;
        period_n    = period;
        ps_n        = ps;
        pc_n        = pc;
        acc_n       = acc;
        timer_n     = timer;
        ramp_eff    = ramp_cnt;

        case (state)
            IDLE: begin
                if (fin) begin
                    // Trailing cycle after the last step: busy is still high here.
                    done_n = !bus.abort;
                end else begin
                    if (bus.load_pos) pos_n = bus.load_val;
                    if (bus.start && !bus.abort) begin
                        if (delta == '0) begin
                            done_n = 1'b1;
                        end else begin
                            dir_n       = !delta[POS_W-1];
                            remaining_n = mag;
                            ramp_cnt_n  = '0;
                            pc_n        = pc_in;
                            acc_n       = bus.accel_dec;
                            if (ps_in > pc_in) begin
                                ps_n     = ps_in;
                                period_n = ps_in;
                                timer_n  = ps_in;
                                state_n  = ACCEL;
                            end else begin
                                ps_n     = pc_in;
                                period_n = pc_in;
                                timer_n  = pc_in;
                                state_n  = CRUISE;
                            end
                        end
                    end
                end
            end
            default: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (timer == PER_W'(1)) begin
                    step_n      = 1'b1;
                    pos_n       = dir ? (pos + POS_W'(1)) : (pos - POS_W'(1));
                    remaining_n = rem_dec;
                    ramp_eff    = (state == ACCEL) ? (ramp_cnt + POS_W'(1)) : ramp_cnt;
                    ramp_cnt_n  = ramp_eff;
                    if (rem_dec == '0) begin
                        state_n = IDLE;
                        fin_n   = 1'b1;
                    end else if (state != DECEL && rem_dec <= ramp_eff) begin
                        state_n  = DECEL;
                        period_n = up_per;
                    end else begin
                        case (state)
                            ACCEL: begin
                                period_n = dn_per;
                                if (dn_per == pc) state_n = CRUISE;
                            end
                            DECEL:   period_n = up_per;
                            default: period_n = period;
                        endcase
                    end
                    timer_n = period_n;
                end else begin
                    timer_n = timer - PER_W'(1);
                end
            end
        endcase
    end

    assign bus.cur_step_pos = pos;
    assign bus.step         = step;
    assign bus.dir          = dir;
    assign bus.busy         = (state != IDLE) || fin;
    assign bus.done         = done;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_step_profile_gen.sv
// Directed bench for step_profile_gen: expected step gap/position pairs are
// queued when a move is launched and popped as step pulses appear.
module tb_step_profile_gen;
  localparam int POS_W = 32;
  localparam int PER_W = 24;
  localparam logic [1:0] S_IDLE = 2'd0, S_ACCEL = 2'd1, S_CRUISE = 2'd2, S_DECEL = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  step_profile_gen_if #(.POS_W(POS_W), .PER_W(PER_W)) bus ();

  step_profile_gen #(.POS_W(POS_W), .PER_W(PER_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Each entry: {gap_since_previous_step[23:0], position_after_step[31:0]}
  logic [55:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int gap_cnt = 0;
  logic exp_dir = 1'b1;
  int trap_gaps[8] = '{10, 7, 4, 4, 4, 4, 7, 10};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_step(input int gap, input logic [31:0] pos);
    exp_q.push_back({24'(gap), pos});
  endtask

  task automatic push_run(input logic [31:0] from, input logic up, input int n, input int gap);
    for (int i = 1; i <= n; i++)
      push_step(gap, up ? (from + 32'(i)) : (from - 32'(i)));
  endtask

  task automatic load(input logic [31:0] v);
    bus.load_pos = 1'b1;
    bus.load_val = v;
    tick();
    bus.load_pos = 1'b0;
    check("load_pos", 64'(bus.cur_step_pos), 64'(v));
  endtask

  task automatic start_move(input logic [31:0] tgt, input logic [23:0] sp, input logic [23:0] cp,
                            input logic [23:0] ad, input logic up);
    exp_dir           = up;
    bus.target_pos    = tgt;
    bus.start_period  = sp;
    bus.cruise_period = cp;
    bus.accel_dec     = ad;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    gap_cnt   = 0;
    check("busy_rise", 64'(bus.busy), 64'(1));
  endtask

  task automatic wait_steps(input int n, input int budget);
    int seen = 0;
    int cyc = 0;
    logic [55:0] e;
    while (seen < n && cyc < budget) begin
      tick();
      cyc++;
      gap_cnt++;
      if (bus.step === 1'b1) begin
        seen++;
        check("sb_has_entry", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("step_gap", 64'(gap_cnt), 64'(e[55:32]));
          check("step_pos", 64'(bus.cur_step_pos), 64'(e[31:0]));
          check("step_dir", 64'(bus.dir), 64'(exp_dir));
        end
        gap_cnt = 0;
      end
    end
    check("steps_in_budget", 64'(seen), 64'(n));
  endtask

  task automatic wait_end(input int budget, input logic exp_done);
    int cyc = 0;
    while (bus.busy === 1'b1 && cyc < budget) begin
      tick();
      cyc++;
      gap_cnt++;
      if (bus.step === 1'b1) check("extra_step", 64'(bus.step), 64'(0));
    end
    check("busy_fell", 64'(bus.busy), 64'(0));
    check("done_pulse", 64'(bus.done), 64'(exp_done));
    if (exp_done) check("done_latency", 64'(gap_cnt), 64'(1));
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    tick();
    check("done_one_cycle", 64'(bus.done), 64'(0));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.load_pos = 1'b0;
    bus.load_val = '0;
    bus.target_pos = '0;
    bus.start_period = '0;
    bus.cruise_period = '0;
    bus.accel_dec = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_pos", 64'(bus.cur_step_pos), 64'(0));
    check("rst_step", 64'(bus.step), 64'(0));
    check("rst_dir", 64'(bus.dir), 64'(1));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_state", 64'(bus.state_dbg), 64'(S_IDLE));

    // Constant-rate forward move
    push_run(32'd0, 1'b1, 5, 4);
    start_move(32'd5, 24'd4, 24'd4, 24'd0, 1'b1);
    check("fwd_state", 64'(bus.state_dbg), 64'(S_CRUISE));
    wait_steps(5, 100);
    wait_end(20, 1'b1);
    check("fwd_final", 64'(bus.cur_step_pos), 64'(5));

    // Reverse move through zero
    load(32'd0);
    push_run(32'd0, 1'b0, 3, 2);
    start_move(32'hFFFF_FFFD, 24'd2, 24'd2, 24'd0, 1'b0);
    wait_steps(3, 50);
    wait_end(20, 1'b1);
    check("rev_final", 64'(bus.cur_step_pos), 64'(32'hFFFF_FFFD));
    check("rev_dir", 64'(bus.dir), 64'(0));

    // Trapezoid
    load(32'd0);
    for (int i = 0; i < 8; i++) push_step(trap_gaps[i], 32'(i + 1));
    start_move(32'd8, 24'd10, 24'd4, 24'd3, 1'b1);
    check("trap_accel", 64'(bus.state_dbg), 64'(S_ACCEL));
    wait_steps(2, 100);
    check("trap_cruise", 64'(bus.state_dbg), 64'(S_CRUISE));
    wait_steps(4, 100);
    check("trap_decel", 64'(bus.state_dbg), 64'(S_DECEL));
    wait_steps(2, 100);
    wait_end(20, 1'b1);

    // Short trapezoid: straight from ACCEL into DECEL
    load(32'd0);
    push_step(10, 32'd1);
    push_step(10, 32'd2);
    start_move(32'd2, 24'd10, 24'd4, 24'd3, 1'b1);
    wait_steps(1, 100);
    check("short_decel", 64'(bus.state_dbg), 64'(S_DECEL));
    wait_steps(1, 100);
    wait_end(20, 1'b1);

    // Load near the signed limit and cross it
    load(32'h7FFF_FFFF);
    push_run(32'h7FFF_FFFF, 1'b1, 2, 2);
    start_move(32'h8000_0001, 24'd2, 24'd2, 24'd0, 1'b1);
    wait_steps(2, 50);
    wait_end(20, 1'b1);
    check("wrap_final", 64'(bus.cur_step_pos), 64'(32'h8000_0001));

    // Zero-length move
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("zero_done", 64'(bus.done), 64'(1));
    check("zero_busy", 64'(bus.busy), 64'(0));
    check("zero_step", 64'(bus.step), 64'(0));
    tick();
    check("zero_done_clr", 64'(bus.done), 64'(0));
    check("zero_pos", 64'(bus.cur_step_pos), 64'(32'h8000_0001));

    // load_pos together with start: delta taken against load_val
    bus.load_pos = 1'b1;
    bus.load_val = 32'd10;
    push_run(32'd10, 1'b1, 2, 2);
    start_move(32'd12, 24'd1, 24'd0, 24'd0, 1'b1);
    bus.load_pos = 1'b0;
    wait_steps(2, 50);
    wait_end(20, 1'b1);
    check("ldst_final", 64'(bus.cur_step_pos), 64'(12));

    // Ignored mid-move start, then abort on a due step
    load(32'd0);
    push_run(32'd0, 1'b1, 4, 3);
    start_move(32'd100, 24'd3, 24'd3, 24'd0, 1'b1);
    wait_steps(2, 50);
    bus.target_pos = 32'd0;
    bus.start = 1'b1;
    tick();
    gap_cnt++;
    bus.start = 1'b0;
    check("ign_busy", 64'(bus.busy), 64'(1));
    check("ign_state", 64'(bus.state_dbg), 64'(S_CRUISE));
    wait_steps(2, 50);
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_step", 64'(bus.step), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_pos", 64'(bus.cur_step_pos), 64'(4));
    check("abort_state", 64'(bus.state_dbg), 64'(S_IDLE));
    tick();
    check("abort_done2", 64'(bus.done), 64'(0));
    check("abort_pos2", 64'(bus.cur_step_pos), 64'(4));

    // abort with start in IDLE drops the start
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.target_pos = 32'd9;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abst_busy", 64'(bus.busy), 64'(0));
    check("abst_done", 64'(bus.done), 64'(0));
    tick();
    check("abst_idle", 64'(bus.busy), 64'(0));

    // Reset mid-move
    load(32'd0);
    push_run(32'd0, 1'b0, 3, 3);
    start_move(32'hFFFF_FFCE, 24'd3, 24'd3, 24'd0, 1'b0);
    wait_steps(3, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mrst_pos", 64'(bus.cur_step_pos), 64'(0));
    check("mrst_step", 64'(bus.step), 64'(0));
    check("mrst_dir", 64'(bus.dir), 64'(1));
    check("mrst_busy", 64'(bus.busy), 64'(0));
    check("mrst_done", 64'(bus.done), 64'(0));
    check("mrst_state", 64'(bus.state_dbg), 64'(S_IDLE));
    push_run(32'd0, 1'b1, 3, 2);
    start_move(32'd3, 24'd2, 24'd2, 24'd0, 1'b1);
    wait_steps(3, 50);
    wait_end(20, 1'b1);
    check("post_rst_final", 64'(bus.cur_step_pos), 64'(3));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/step_profile_gen.md
# step_profile_gen

Trapezoidal step-pulse generator that sits directly upstream of the full-step waveform decoder in the stepper driver. It moves the current step position toward a target at a programmable rate, with a linear period ramp for acceleration and deceleration. Its outputs drive the following consumers:
- `cur_step_pos[1:0]` drives the waveform decoder.
- `cur_step_pos` is readable through SPI register 0.
- `step`/`dir` can be mirrored to the external step/dir pins.

## Interface
- `POS_W`, 32, width of position and target (two's complement)
- `PER_W`, 24, width of all period/ramp quantities (clock cycles)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a move to `target_pos`
- `abort`  in  1  stop immediately, no further steps
- `load_pos`  in  1  overwrite `cur_step_pos` with `load_val` (ignored while `busy`)
- `load_val`  in  POS_W  position load value
- `target_pos`  in  POS_W  signed move target, sampled on `start`
- `start_period`  in  PER_W  step interval at ramp start/end, sampled on `start`
- `cruise_period`  in  PER_W  minimum step interval, sampled on `start`
- `accel_dec`  in  PER_W  period change per step while ramping, sampled on `start`
- `cur_step_pos`  out  POS_W  current position
- `step`  out  1  one-cycle pulse per step taken
- `dir`  out  1  1 = incrementing, 0 = decrementing
- `busy`  out  1  move in progress
- `done`  out  1  one-cycle pulse on normal move completion

## Operation
- **States:** IDLE, ACCEL, CRUISE, DECEL.
- **Start from IDLE (`start`=1):**
  - `delta` = `target_pos` − `cur_step_pos`, computed modulo 2^POS_W and read as signed.
  - If `delta` = 0: pulse `done`, stay IDLE.
  - Otherwise:
    - `dir` = (`delta` > 0).
    - `remaining` = |`delta|`, unsigned; −2^31 gives 2^31.
    - `ramp_cnt` = 0.
    - Latch `Ps` = max(`start_period`, 2) and `Pc` = max(`cruise_period`, 2).
    - If `Ps` > `Pc`, set `period` = `Ps` and go to ACCEL. Otherwise set `period` = `Pc`, `Ps` := `Pc`, and go to CRUISE.
- **Start outside IDLE:** `start` while `busy` is ignored. Latched parameters are not updated.
- **Interval timer:** `timer` is loaded with `period`. A step fires when `period` cycles have elapsed since the previous step (or since `busy` rose).
- **On each step**, all updates are registered together:
  - `cur_step_pos` ±1, wrapping modulo 2^POS_W.
  - `remaining` −1.
  - `step` = 1.
- **Next-period rules**, evaluated in this order on each step:
  1. If state is ACCEL: `ramp_cnt` += 1.
  2. If `remaining` after the step is 0: go to IDLE.
  3. Else, if state ≠ DECEL and `remaining` ≤ `ramp_cnt`: go to DECEL with `period` = min(`period` + `accel_dec`, `Ps`).
  4. Else, per state:
     - ACCEL: `period` = max(`period` − `accel_dec`, `Pc`). Go to CRUISE when the result equals `Pc`.
     - CRUISE: `period` unchanged.
     - DECEL: `period` = min(`period` + `accel_dec`, `Ps`).
- **Period arithmetic:** computed PER_W+1 bits wide, so the add cannot overflow before clamping. The subtract clamps at `Pc` and cannot underflow.
- **`accel_dec` = 0:** a legal constant-rate move at `Ps`.
- **`abort`:**
  - While `busy`, `abort` returns to IDLE on the next edge.
  - No step is taken that cycle, even if the timer expires. `abort` wins.
  - `cur_step_pos` holds and `done` is not pulsed.
  - `abort` together with `start` in IDLE: `abort` wins, the start is dropped.
- **`load_pos`:** in IDLE, `load_pos` together with `start` applies the load first. `delta` is computed against `load_val`.
- **Reset:** `rst` mid-move returns to IDLE immediately.

## Timing
- **Reset values:** `cur_step_pos`=0, `step`=0, `dir`=1, `busy`=0, `done`=0, state IDLE.
- **Busy rise:** `start` is sampled at edge E0. `busy`=1 after E0.
- **First step:** `step` is high in the cycle after edge E0+`period`, i.e. `period` cycles after `busy` rises.
- **Subsequent steps:** each occurs the chosen number of cycles after the previous `step` high cycle.
- **Step/position alignment:** `cur_step_pos` updates on the same edge that raises `step`. The new position is visible while `step`=1.
- **End of a normal move:** on the edge after the last `step`, `busy` falls and `done` rises for one cycle.
- **Zero move:** `done`=1 in the cycle after E0. `busy` stays 0.
- **`load_pos` in IDLE:** `cur_step_pos` = `load_val` after one edge.

## Test plan
- **Constant-rate forward move.** Stimulus: pos 0, target 5, start=cruise=4, `accel_dec`=0. Required:
  - 5 `step` pulses, spaced 4 cycles apart; the first comes 4 cycles after `busy` rises.
  - `dir`=1 and final pos 5.
  - `done` in the cycle after the 5th step.
- **Reverse move with wrap.** Stimulus: pos 0, target −3, period 2. Required: `dir`=0, 3 steps, final pos 0xFFFFFFFD.
- **Trapezoidal profile.** Stimulus: pos 0, target 8, start 10, cruise 4, accel 3. Required:
  - Step intervals 10, 7, 4, 4, 4, 4, 7, 10.
  - DECEL entered after the 6th step.
  - Short-move variant, target 2: intervals 10, 10.
- **Zero move and position load.** Stimulus: `load_pos` with 0x7FFFFFFF, then target 0x80000001. Required:
  - 2 steps with `dir`=1; pos reaches 0x80000001.
  - Restarting with the same target: `done` the next cycle, no `step`, `busy` stays 0.
- **Abort and ignored start.** Stimulus: target 100, period 3. Pulse `start` with target 0 after the 2nd step, then `abort` after the 4th step. Required:
  - The mid-move `start` has no effect.
  - `busy` falls the next edge with no `done`, and pos holds at 4.
  - `abort` coincident with a due step suppresses that step.
- **Reset mid-move.** Stimulus: assert `rst` during a move. Required: all outputs return to reset values, and a fresh move completes normally afterwards.
